// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM states, request bundle and the funct3 legality helper.
package dmem_pkg;

  // Load/store size encodings carried on funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of the wait-state counter; covers WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // One captured request.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } req_t;

  // Encodings with no meaning, plus unsigned variants used on a store.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous word array: byte-enable write and registered read share
// one enable and one address, both acting on the same clock edge.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write the enabled lanes and register the old word (read-before-write).
  // NOTE: storage and its read register carry no reset; a reset loop over the
  // whole array would block RAM inference and the contents are defined by use.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I core's load/store port.
// One request at a time over valid/ready, WAIT_CYCLES wait states, lane
// steering and load extension, single-cycle response pulse.
// Optional build macro DMEM_ALIGN_CHECK_EN: reject misaligned halves/words
// with rsp_err instead of silently clearing the low address bits.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  req_t             cap_q;
  req_t             acc;
  logic             accept;
  logic             access;

  logic [31:0]      acc_addr;
  logic             misalign;
  logic             acc_err;
  logic [1:0]       acc_lane;
  logic [3:0]       lane_be;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic [31:0]      rd_word;

  logic             ok_q;
  logic             err_q;
  logic [1:0]       lane_q;
  logic [2:0]       f3_q;

  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic             unused_addr_bits;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and the access strobe; reset overrides every transition.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
      access  = 1'b0;
    end
  end

  // Wait-state counter: loaded on acceptance, counts down in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_INIT;
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Capture the request fields on acceptance (datapath only, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) cap_q <= '{we: req_we, addr: req_addr, funct3: req_funct3, wdata: req_wdata};
  end

  // Access source: live inputs when the access happens on the acceptance edge
  // (zero wait states), otherwise the captured request.
  always_comb begin
    if (state_q == IDLE) acc = '{we: req_we, addr: req_addr, funct3: req_funct3, wdata: req_wdata};
    else                 acc = cap_q;
  end

  // Alignment handling, error decode and store lane steering.
  always_comb begin
    acc_addr = acc.addr;
    misalign = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = ((acc.funct3[1:0] == 2'b01) && acc.addr[0]) ||
               ((acc.funct3[1:0] == 2'b10) && (acc.addr[1:0] != 2'b00));
`else
    if (acc.funct3[1:0] == 2'b01) acc_addr[0]   = 1'b0;
    if (acc.funct3[1:0] == 2'b10) acc_addr[1:0] = 2'b00;
`endif
    acc_err  = f3_illegal(acc.we, acc.funct3) || misalign;
    acc_lane = acc_addr[1:0];

    lane_be   = 4'b0000;
    mem_wdata = acc.wdata;
    case (acc.funct3[1:0])
      2'b00: begin
        lane_be   = 4'b0001 << acc_lane;
        mem_wdata = {4{acc.wdata[7:0]}};
      end
      2'b01: begin
        lane_be   = acc_lane[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{acc.wdata[15:0]}};
      end
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
    mem_be = (access && acc.we && !acc_err) ? lane_be : 4'b0000;
  end

  // Address bits above the word index are deliberately ignored (wrap).
  assign unused_addr_bits = ^acc_addr[31:AW+2];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (access),
    .be    (mem_be),
    .addr  (acc_addr[AW+1:2]),
    .wdata (mem_wdata),
    .rdata (rd_word)
  );

  // Response controls registered alongside the array read on the access edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      lane_q <= 2'b00;
      f3_q   <= 3'b000;
    end else if (access) begin
      ok_q   <= !acc.we && !acc_err;
      err_q  <= acc_err;
      lane_q <= acc_lane;
      f3_q   <= acc.funct3;
    end
  end

  // Load extension from the registered word; zero for stores, errors, reset.
  always_comb begin
    sel_byte  = rd_word[8*lane_q +: 8];
    sel_half  = rd_word[16*lane_q[1] +: 16];
    rsp_rdata = 32'h0;
    if (ok_q) begin
      case (f3_q)
        F3_B:    rsp_rdata = {{24{sel_byte[7]}}, sel_byte};
        F3_BU:   rsp_rdata = {24'h0, sel_byte};
        F3_H:    rsp_rdata = {{16{sel_half[15]}}, sel_half};
        F3_HU:   rsp_rdata = {16'h0, sel_half};
        F3_W:    rsp_rdata = rd_word;
        default: rsp_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RV32I core: the memory end of the core's load/store interface (MemRead/MemWrite, ALU-computed address, RD2 store data, funct3 size). It accepts one request at a time over a valid/ready handshake, models a configurable number of wait states, performs byte/half/word access with lane steering and load sign/zero extension, and returns a single-cycle response pulse. It sits between the core's ALU/register-file outputs and the MemtoReg write-back mux.

## Interface
- DEPTH_WORDS, 256: storage depth in 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 1: wait states between acceptance and access; 0..15.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE and when rst low
- req_we  in  1  1 = store (MemWrite), 0 = load (MemRead)
- req_addr  in  32  byte address
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  32  store data; lanes taken from LSBs
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected; valid only with rsp_valid

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready on a clk edge. On acceptance, we/addr/funct3/wdata are captured. If WAIT_CYCLES=0, next state is RESP; otherwise next state is WAIT with counter=WAIT_CYCLES-1.
- WAIT: counter decrements each cycle. Counter==0 performs the access and moves to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Access occurs on the edge entering RESP. A store commits there; load data is registered there.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap.
- Byte lane = addr[1:0]. A byte uses lane addr[1:0]; a half uses lanes addr[1]*2 and +1; a word uses all 4 lanes.
- Loads: B/H are sign-extended from the selected byte or half. BU/HU are zero-extended. W is unmodified.
- Stores write only the selected lanes from wdata[7:0] (B), wdata[15:0] (H) or wdata (W). Other lanes are untouched.
- Illegal funct3 sets rsp_err=1, performs no write and returns rdata=0. Illegal means 011/110/111, or a store with 100/101.
- Reset values: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. Memory contents are not reset.
- Reset mid-operation abandons the request. A store that has not reached its commit edge is not written, and no response is issued.

## Timing
- Latency from the acceptance edge to rsp_valid high is WAIT_CYCLES+1 cycles.
- Throughput is one request per WAIT_CYCLES+2 cycles. req_ready drops the cycle after acceptance and rises the cycle after RESP.
- rsp_rdata and rsp_err are registered and stable during the RESP cycle. They hold their last value afterwards until the next RESP.
- req_valid while req_ready=0 is ignored and is not queued.
- rst has priority over every transition, including acceptance in the same cycle.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A half with addr[0]=1 is misaligned, and so is a word with addr[1:0]!=0.
  - A misaligned request sets rsp_err=1, performs no write and returns rdata=0. Latency is unchanged.
- DMEM_ALIGN_CHECK_EN undefined:
  - The ignored low bits are forced to zero: addr[0] for halves, addr[1:0] for words.
  - The access proceeds normally and rsp_err reflects only illegal funct3.

## Structure
- Package dmem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state enum {IDLE, WAIT, RESP}
  - WAIT counter width constant (4)
- Sub-module dmem_array: synchronous word array with a 4-bit byte-enable write port and a read port, registered in the same edge. The FSM, lane steering and extension stay in dmem_responder.

## Test plan
- WAIT_CYCLES=1: SW 0xDEADBEEF @0x10, then LW @0x10 → each response arrives 2 cycles after acceptance; rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x11 over word 0x00000000, then LB @0x11 → 0xFFFFFF80; LBU @0x11 → 0x00000080; LW @0x10 → 0x00008000.
- SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001; LHU → 0x00008001.
- funct3=011 load, and store with funct3=100 → err=1, rdata=0, target word unchanged on readback.
- With DMEM_ALIGN_CHECK_EN: LW @0x13 → err=1. Without it: LW @0x13 returns the word @0x10, err=0.
- Assert rst during WAIT of SW 0x12345678 @0x0 → no rsp_valid, req_ready high the cycle after rst deasserts, LW @0x0 returns the prior contents.
